// File: rtl/mino_sampler.sv
`default_nettype none
// ============================================================================
// Module   : mino_sampler
// Purpose  : Oversampling front end for the 3-input minority detector.
//            Synchronizes an asynchronous serial line, aligns a free-running
//            bit-period counter to the first line transition, and once per
//            bit period presents a registered triplet (x, y, z) taken at the
//            quarter, half and three-quarter points of the period. A
//            valid/ready handshake feeds the detector; a sticky overrun flag
//            records any completed triplet that had to be dropped.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            din    - asynchronous serial line
//            en     - enable; low forces IDLE and clears valid/ovr
//            ready  - downstream accepts the presented triplet this cycle
//            x/y/z  - samples at DIV/4, DIV/2, 3*DIV/4 of the bit period
//            valid  - x/y/z hold an unconsumed triplet
//            ovr    - sticky: a completed triplet was dropped
// Revision : 1.0 - initial release
// ============================================================================
module mino_sampler #(
    parameter int DIV = 16    // clock cycles per bit period; multiple of 4, >= 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic en,
    input  logic ready,
    output logic x,
    output logic y,
    output logic z,
    output logic valid,
    output logic ovr
);

    localparam int c_cw = $clog2(DIV);

    localparam logic [c_cw-1:0] c_cnt_x    = c_cw'(DIV / 4);
    localparam logic [c_cw-1:0] c_cnt_y    = c_cw'(DIV / 2);
    localparam logic [c_cw-1:0] c_cnt_z    = c_cw'((3 * DIV) / 4);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;

    // Two-flop synchronizer plus one history flop for edge detection.
    logic r_s1;
    logic r_din_s;
    logic r_din_d;

    // Samples of the period currently being collected.
    logic r_sx;
    logic r_sy;
    logic r_sz;

    logic w_edge;
    logic w_xfer;

    assign w_edge = r_din_s ^ r_din_d;
    // Last cycle of a bit period: all three samples of this period are in.
    assign w_xfer = (r_state == ST_RUN) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_s1    <= 1'b0;
            r_din_s <= 1'b0;
            r_din_d <= 1'b0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_sz    <= 1'b0;
            x       <= 1'b0;
            y       <= 1'b0;
            z       <= 1'b0;
            valid   <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            // The synchronizer runs regardless of enable so that a fresh
            // alignment after re-enable never sees a stale, spurious edge.
            r_s1    <= din;
            r_din_s <= r_s1;
            r_din_d <= r_din_s;

            if (!en) begin
                // Partial triplet is abandoned; x/y/z keep stale values,
                // which are meaningless while valid is low.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                valid   <= 1'b0;
                ovr     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt   <= '0;
                        r_state <= ST_ALIGN;
                    end
                    ST_ALIGN: begin
                        if (w_edge) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RUN: begin
                        // Free-running: later line edges never re-align.
                        r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
                        if (r_cnt == c_cnt_x) r_sx <= r_din_s;
                        if (r_cnt == c_cnt_y) r_sy <= r_din_s;
                        if (r_cnt == c_cnt_z) r_sz <= r_din_s;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase

                if (w_xfer) begin
                    // A load in the same cycle as ready both retires the old
                    // triplet and presents the new one, so valid stays high.
                    if (!valid || ready) begin
                        x     <= r_sx;
                        y     <= r_sy;
                        z     <= r_sz;
                        valid <= 1'b1;
                    end else begin
                        ovr   <= 1'b1;
                    end
                end else if (valid && ready) begin
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mino_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mino_sampler
// Purpose  : Self-checking bench for mino_sampler (DIV = 16). A history-based
//            reference model derives every triplet directly from the record
//            of line values seen at each clock edge; a compare process checks
//            all outputs on every falling edge, and directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mino_sampler;

    localparam int DIV = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic en    = 1'b0;
    logic ready = 1'b0;
    logic x, y, z, valid, ovr;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    mino_sampler #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .en    (en),
        .ready (ready),
        .x     (x),
        .y     (y),
        .z     (z),
        .valid (valid),
        .ovr   (ovr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. hist[k] is the line value at the k-th clock edge
    // since reset. The synchronized line seen at edge n is hist[n-2], and
    // a triplet completing at edge n was sampled 3*DIV/4-1, DIV/2-1 and
    // DIV/4-1 edges earlier.
    // ------------------------------------------------------------------
    logic hist [0:4095];
    int   n       = 0;
    int   m_mode  = 0;     // 0 disabled, 1 waiting for a line edge, 2 running
    int   m_start = 0;     // edge index at which running began
    logic m_x = 1'b0, m_y = 1'b0, m_z = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
    logic m_edge, m_xfer;

    function automatic logic past(input int k);
        if (k < 0 || k > 4095) return 1'b0;
        return hist[k];
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            n       = 0;
            m_mode  = 0;
            m_start = 0;
            m_x     = 1'b0;
            m_y     = 1'b0;
            m_z     = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (n <= 4095) hist[n] = din;
            m_edge = past(n - 2) ^ past(n - 3);
            m_xfer = (m_mode == 2) && (n > m_start) && (((n - m_start) % DIV) == 0);
            if (!en) begin
                m_mode  = 0;
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end else begin
                if (m_xfer) begin
                    if (!m_valid || ready) begin
                        m_x     = past(n - (3 * DIV) / 4 - 1);
                        m_y     = past(n - DIV / 2 - 1);
                        m_z     = past(n - DIV / 4 - 1);
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && ready) begin
                    m_valid = 1'b0;
                end
                if (m_mode == 0) begin
                    m_mode = 1;
                end else if (m_mode == 1 && m_edge) begin
                    m_mode  = 2;
                    m_start = n;
                end
            end
            n++;
        end
    end

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One compare process against the model on every cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model_valid", valid, m_valid);
            cmp("model_ovr", ovr, m_ovr);
            if (m_valid) begin
                cmp("model_x", x, m_x);
                cmp("model_y", y, m_y);
                cmp("model_z", z, m_z);
            end
        end
    end

    // Advance one clock edge; inputs are then changed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_trip(input string name, input logic ex, input logic ey, input logic ez);
        cmp({name, "_x"}, x, ex);
        cmp({name, "_y"}, y, ey);
        cmp({name, "_z"}, z, ez);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        chk_on = 1'b1;
        cmp("reset_valid", valid, 1'b0);
        cmp("reset_ovr", ovr, 1'b0);
        chk_trip("reset", 1'b0, 1'b0, 1'b0);

        // ---------------- alignment and latency ----------------
        // Line goes high before edge 1; cnt is 0 after edge 3.
        rst_n = 1'b1; en = 1'b1; ready = 1'b1; din = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            if (e == 18) cmp("lat_valid_e18", valid, 1'b0);
            if (e == 19) begin
                cmp("lat_valid_e19", valid, 1'b1);
                chk_trip("lat_e19", 1'b1, 1'b1, 1'b1);
            end
            if (e == 20) cmp("lat_valid_e20", valid, 1'b0);
            if (e == 34) cmp("lat_valid_e34", valid, 1'b0);
            if (e == 35) cmp("lat_valid_e35", valid, 1'b1);
        end

        // ---------------- mixed samples (edges 36..51) ----------------
        // Line value driven during cnt c shows on din_s at cnt c+2.
        for (int c = 0; c < DIV; c++) begin
            din = (c < 4) ? 1'b1 : ((c < 8) ? 1'b0 : 1'b1);
            tick();
        end
        cmp("mixed_valid", valid, 1'b1);
        chk_trip("mixed", 1'b1, 1'b0, 1'b1);

        // ---------------- simultaneous load/consume ----------------
        din = 1'b1;
        for (int c = 0; c < DIV; c++) begin   // edges 52..67
            ready = (c == 0);
            tick();
        end
        cmp("sim_valid_e67", valid, 1'b1);
        chk_trip("sim_e67", 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < DIV; c++) begin   // edges 68..83
            din   = (c < 4) ? 1'b0 : ((c < 8) ? 1'b1 : 1'b0);
            ready = (c == DIV - 1);
            tick();
            if (c == DIV - 2) chk_trip("sim_hold", 1'b1, 1'b1, 1'b1);
        end
        cmp("sim_valid_e83", valid, 1'b1);
        cmp("sim_ovr_e83", ovr, 1'b0);
        chk_trip("sim_e83", 1'b0, 1'b1, 1'b0);

        // ---------------- overrun (edges 84..115) ----------------
        ready = 1'b0;
        din   = 1'b1;
        for (int k = 1; k <= 2 * DIV; k++) begin
            tick();
            if (k == DIV - 1) cmp("ovr_before", ovr, 1'b0);
            if (k == DIV) begin
                cmp("ovr_set", ovr, 1'b1);
                cmp("ovr_valid", valid, 1'b1);
                chk_trip("ovr_held1", 1'b0, 1'b1, 1'b0);
            end
            if (k == 2 * DIV) chk_trip("ovr_held2", 1'b0, 1'b1, 1'b0);
        end
        ready = 1'b1;
        tick();                                // edge 116
        ready = 1'b0;
        cmp("ovr_consume_valid", valid, 1'b0);
        cmp("ovr_sticky", ovr, 1'b1);

        // ---------------- disable mid-period ----------------
        for (int k = 1; k <= 24; k++) begin    // edges 117..140, cnt=9 after 140
            tick();
            if (k == 15) begin
                cmp("dis_pre_valid", valid, 1'b1);
                cmp("dis_pre_ovr", ovr, 1'b1);
            end
        end
        en = 1'b0;
        tick();                                // edge 141
        cmp("dis_valid", valid, 1'b0);
        cmp("dis_ovr", ovr, 1'b0);
        repeat (2) tick();
        en = 1'b1;
        repeat (40) tick();
        cmp("realign_wait_valid", valid, 1'b0);
        din = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 18) cmp("realign_valid_e18", valid, 1'b0);
            if (e == 19) begin
                cmp("realign_valid_e19", valid, 1'b1);
                chk_trip("realign", 1'b0, 1'b0, 1'b0);
            end
        end

        // ---------------- asynchronous reset mid-run ----------------
        #2;
        rst_n = 1'b0;
        #1;
        cmp("areset_valid", valid, 1'b0);
        cmp("areset_ovr", ovr, 1'b0);
        chk_trip("areset", 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1; en = 1'b1; ready = 1'b1; din = 1'b0;
        repeat (40) tick();
        cmp("post_reset_align_valid", valid, 1'b0);
        din = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 19) begin
                cmp("post_reset_valid", valid, 1'b1);
                chk_trip("post_reset", 1'b1, 1'b1, 1'b1);
            end
        end

        repeat (2) tick();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
